// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI configuration-register controller:
// frame geometry, register addresses and the frame FSM encoding.
package spi_reg_pkg;

   localparam int FRAME_BITS = 16;
   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      COMMIT  = 2'd2,
      DISCARD = 2'd3
   } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              q_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain  <= '0;
         q_prev <= 1'b0;
      end else begin
         chain  <= {chain[STAGES-2:0], d};
         q_prev <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~q_prev;
   assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_register_ctrl.sv
// SPI mode-0 peripheral writing five 8-bit configuration registers from 16-bit
// frames. Define SPI_READBACK_EN to add register readback on cipo.
module spi_register_ctrl
   import spi_reg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   logic sclk_q, sclk_rise, sclk_fall;
   logic ncs_q, ncs_rise, ncs_fall;
   logic copi_q, copi_rise_unused, copi_fall_unused;
   logic sclk_q_unused, ncs_q_unused;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk (clk), .rst_n(rst_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk (clk), .rst_n(rst_n), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk (clk), .rst_n(rst_n), .d(copi), .q(copi_q), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   assign sclk_q_unused = sclk_q;
   assign ncs_q_unused  = ncs_q;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [15:0] shift_reg;
   logic [15:0] shift_nxt;
   logic        frame_start;
   logic        bit_take;
   logic        wr_en;

   assign shift_nxt   = {shift_reg[14:0], copi_q};
   assign frame_start = (state_nxt == SHIFT) && (state != SHIFT);
   // An ncs rise outranks a coincident sclk edge: the frame is already over.
   assign bit_take    = (state == SHIFT) && sclk_rise && !ncs_rise && (cnt != CNT_FULL);
   assign wr_en       = (state == COMMIT) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt is assigned before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ncs_fall) state_nxt = SHIFT;
         SHIFT: begin
            if (ncs_rise)                             state_nxt = (cnt == CNT_FULL) ? COMMIT : IDLE;
            else if (sclk_rise && (cnt == CNT_FULL))  state_nxt = DISCARD;
         end
         COMMIT:  state_nxt = ncs_fall ? SHIFT : IDLE;
         DISCARD: if (ncs_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         shift_reg <= '0;
      end else if (frame_start) begin
         cnt       <= '0;
         shift_reg <= '0;
      end else if (bit_take) begin
         cnt       <= cnt + 5'd1;
         shift_reg <= shift_nxt;
      end
   end

   // NOTE: the register file is small and drives a peripheral directly, so
   // every entry is reset rather than left to power-up contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else if (wr_en) begin
         case (shift_reg[14:8])
            ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shift_reg[7:0];
            ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shift_reg[7:0];
            ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shift_reg[7:0];
            ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shift_reg[7:0];
            ADDR_PWM_DUTY:    pwm_duty_cycle  <= shift_reg[7:0];
            default: ;
         endcase
      end
   end

`ifdef SPI_READBACK_EN
   logic [6:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] tx_reg;

   assign rd_addr = shift_nxt[6:0];

   always_comb begin
      rd_data = '0;
      if (rd_addr <= MAX_ADDR) begin
         case (rd_addr)
            ADDR_EN_OUT_7_0:  rd_data = en_reg_out_7_0;
            ADDR_EN_OUT_15_8: rd_data = en_reg_out_15_8;
            ADDR_EN_PWM_7_0:  rd_data = en_reg_pwm_7_0;
            ADDR_EN_PWM_15_8: rd_data = en_reg_pwm_15_8;
            ADDR_PWM_DUTY:    rd_data = pwm_duty_cycle;
            default:          rd_data = '0;
         endcase
      end
   end

   // Load on the 8th rise; the MSB must then stay put until the host samples it
   // on rise 9, so shifting starts with the falling edge after that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_reg <= '0;
      end else if (frame_start) begin
         tx_reg <= '0;
      end else if (bit_take && (cnt == 5'd7) && !shift_nxt[7]) begin
         tx_reg <= rd_data;
      end else if ((state == SHIFT) && sclk_fall && (cnt >= 5'd9)) begin
         tx_reg <= {tx_reg[6:0], 1'b0};
      end
   end

   assign cipo = (state == SHIFT) & tx_reg[7];
`else
   logic sclk_fall_unused;
   assign sclk_fall_unused = sclk_fall;
   assign cipo             = 1'b0;
`endif

endmodule

// File: tb/tb_spi_register_ctrl.sv
// Self-checking bench for spi_register_ctrl: a register model feeds a queue of
// expected register snapshots that are compared after each committed frame.
module tb_spi_register_ctrl;
   import spi_reg_pkg::*;

   localparam int         SS   = 2;
   localparam logic [6:0] MAXA = 7'h04;
   localparam int         HALF = 6;

   typedef logic [4:0][7:0] snap_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic       cipo;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model [5];
   snap_t      sb_q [$];
   logic [7:0] rx;
   logic       cipo_seen_high = 1'b0;

   spi_register_ctrl #(.SYNC_STAGES(SS), .MAX_ADDR(MAXA)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .cipo            (cipo),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (cipo === 1'b1) cipo_seen_high <= 1'b1;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic snap_t snap();
      snap_t s;
      for (int i = 0; i < 5; i++) s[i] = model[i];
      return s;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
   endtask

   // One SPI bit in mode 0: data set up while sclk is low, sampled on the rise.
   task automatic drive_bit(input logic b, input int pos, inout logic [7:0] rxv);
      copi = b;
      wait_clk(HALF);
      if (pos >= 8 && pos <= 15) rxv = {rxv[6:0], cipo};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [16:0] bits, input int nbits, input bit push,
                             output logic [7:0] rxv);
      logic [6:0] a;
      rxv = '0;
      ncs = 1'b0;
      wait_clk(HALF);
      for (int i = nbits - 1; i >= 0; i--) drive_bit(bits[i], nbits - 1 - i, rxv);
      wait_clk(HALF);
      ncs  = 1'b1;
      copi = 1'b0;
      a = bits[14:8];
      if (nbits == FRAME_BITS && bits[15] && a <= MAXA && a < 7'd5) model[a] = bits[7:0];
      if (push) sb_q.push_back(snap());
   endtask

   // Called right after ncs rises: every write must be visible SS+2 edges later.
   task automatic check_regs(input string tag);
      snap_t e;
      repeat (SS + 2) @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_out_7_0"},  en_reg_out_7_0,  e[0]);
         check({tag, "_out_15_8"}, en_reg_out_15_8, e[1]);
         check({tag, "_pwm_7_0"},  en_reg_pwm_7_0,  e[2]);
         check({tag, "_pwm_15_8"}, en_reg_pwm_15_8, e[3]);
         check({tag, "_duty"},     pwm_duty_cycle,  e[4]);
      end
      wait_clk(4);
   endtask

   initial begin
      model_clear();
      wait_clk(3);
      sb_q.push_back(snap());
      check_regs("reset_held");
      check("reset_cipo", {7'b0, cipo}, 8'h00);
      rst_n = 1'b1;
      wait_clk(5);

      send_frame({1'b0, 1'b1, ADDR_EN_OUT_7_0, 8'hA5}, 16, 1'b1, rx);
      check_regs("wr_a5");

      send_frame({1'b0, 1'b1, ADDR_PWM_DUTY, 8'h80}, 16, 1'b1, rx);
      check_regs("wr_duty");
      send_frame({1'b0, 1'b1, 7'h10, 8'hFF}, 16, 1'b1, rx);
      check_regs("wr_oob");

      send_frame({2'b0, 1'b1, ADDR_EN_OUT_15_8, 7'h1E}, 15, 1'b1, rx);
      check_regs("short15");
      send_frame({1'b1, ADDR_EN_OUT_15_8, 8'h3C, 1'b1}, 17, 1'b1, rx);
      check_regs("long17");

      send_frame({1'b0, 1'b1, ADDR_EN_PWM_7_0, 8'h5A}, 16, 1'b1, rx);
      check_regs("wr_5a");
      send_frame({1'b0, 1'b0, ADDR_EN_PWM_7_0, 8'hC3}, 16, 1'b1, rx);
`ifdef SPI_READBACK_EN
      check("rd_cipo_5a", rx, 8'h5A);
`endif
      check_regs("rd_frame");
      send_frame({1'b0, 1'b0, 7'h10, 8'h00}, 16, 1'b1, rx);
`ifdef SPI_READBACK_EN
      check("rd_cipo_oob", rx, 8'h00);
`endif
      check_regs("rd_oob");

      // Reset 10 bits into a write frame; the rest of it must be ignored.
      begin
         logic [15:0] f;
         f   = {1'b1, ADDR_EN_PWM_7_0, 8'hFF};
         rx  = '0;
         ncs = 1'b0;
         wait_clk(HALF);
         for (int i = 15; i >= 6; i--) drive_bit(f[i], 15 - i, rx);
         rst_n = 1'b0;
         model_clear();
         wait_clk(3);
         rst_n = 1'b1;
         wait_clk(4);
         for (int i = 5; i >= 0; i--) drive_bit(f[i], 15 - i, rx);
         wait_clk(HALF);
         ncs = 1'b1;
         sb_q.push_back(snap());
         check_regs("rst_abort");
      end
      send_frame({1'b0, 1'b1, ADDR_EN_PWM_7_0, 8'h77}, 16, 1'b1, rx);
      check_regs("after_rst");

      // Back-to-back: ncs high for only SS+1 clk cycles between frames.
      send_frame({1'b0, 1'b1, ADDR_EN_PWM_15_8, 8'h11}, 16, 1'b0, rx);
      wait_clk(SS + 1);
      send_frame({1'b0, 1'b1, ADDR_PWM_DUTY, 8'h22}, 16, 1'b1, rx);
      check_regs("b2b");

      check("cipo_idle", {7'b0, cipo}, 8'h00);
`ifndef SPI_READBACK_EN
      check("cipo_never_high", {7'b0, cipo_seen_high}, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spi_register_ctrl.md
SPI_REGISTER_CTRL -- requirements
Module: spi_register_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers (minimum 2).
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 SHALL have port clk, input, 1: the single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port sclk, input, 1: SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1: SPI controller-out/peripheral-in data.
REQ-007 SHALL have port ncs, input, 1: SPI chip select, active-low.
REQ-008 SHALL have port cipo, output, 1: SPI read data (readback build only; else constant 0).
REQ-009 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, each output, 8: configuration registers at addresses 0x00..0x04, driving the PWM peripheral.

Function
REQ-010 SHALL pass sclk, copi and ncs through SYNC_STAGES-deep synchronizers; all edges are detected on synchronized values only.
REQ-011 SHALL use SPI mode 0: copi sampled on synchronized sclk rising edge, MSB first; sclk edges while ncs high are ignored.
REQ-012 SHALL use a 16-bit frame: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-013 SHALL have FSM states IDLE, SHIFT, COMMIT and DISCARD.
REQ-014 IDLE -> SHIFT on synchronized ncs falling edge; bit counter cleared to 0.
REQ-015 SHIFT: each sclk rising edge shifts one bit in and increments the 5-bit counter; a 17th edge -> DISCARD.
REQ-016 SHIFT -> COMMIT on ncs rising edge when counter == 16; -> IDLE when counter != 16, with no register change.
REQ-017 COMMIT lasts exactly one clk cycle; it writes data to the addressed register only if R/W = 1 and address <= MAX_ADDR; then -> IDLE.
REQ-018 DISCARD holds until ncs rising edge, then -> IDLE; it never writes.
REQ-019 A written register SHALL change no later than SYNC_STAGES+2 clk rising edges after ncs rises at the pin; all other registers hold.
REQ-020 Writes to address > MAX_ADDR and read frames SHALL leave all registers unchanged.
REQ-021 An ncs falling edge in the same cycle as COMMIT SHALL be accepted: the next state is SHIFT with a cleared counter, after the commit completes.
REQ-022 Frames SHALL be fully independent; no state carries over between transactions except register contents.

Reset
REQ-023 rst_n low SHALL immediately clear all five registers, the shift register, the counter and the synchronizers to 0, set FSM to IDLE and cipo to 0.
REQ-024 Reset during a frame SHALL abort it; after release the FSM waits in IDLE for the next ncs falling edge, so a frame already in progress is never committed.

Configuration
REQ-025 Macro SPI_READBACK_EN defined: on a read frame, after the 8th sclk rising edge, the addressed register (0 when address > MAX_ADDR) loads a transmit shifter; cipo presents its MSB and shifts on each synchronized sclk falling edge; cipo is 0 while ncs is high.
REQ-026 Macro SPI_READBACK_EN undefined: cipo SHALL be constant 0, the transmit shifter SHALL be absent, and read frames are parsed and discarded.

Structure
REQ-027 Package spi_reg_pkg SHALL hold the FSM state enum, FRAME_BITS = 16, and the address constants ADDR_EN_OUT_7_0 = 0x00 through ADDR_PWM_DUTY = 0x04.
REQ-028 Sub-module spi_sync SHALL implement the synchronizer chain plus rise/fall edge-detect pulses for one signal, instantiated once each for sclk, ncs and copi (copi uses level only).

Verification
REQ-029 Write 0x80,0xA5 (addr 0, data 0xA5) -> en_reg_out_7_0 = 0xA5 within SYNC_STAGES+2 clk edges of ncs rise; other registers stay 0.
REQ-030 Write addr 0x04, data 0x80, then addr 0x10, data 0xFF -> pwm_duty_cycle = 0x80; no register is changed by the second frame.
REQ-031 Frames of 15 bits and 17 bits carrying write addr 0x01, data 0x3C -> en_reg_out_15_8 remains 0.
REQ-032 rst_n asserted after 10 bits of write addr 0x02, data 0xFF, then released with ncs still low and the frame completed -> en_reg_pwm_7_0 = 0; a following valid frame commits normally.
REQ-033 Back-to-back frames with ncs high for only SYNC_STAGES+1 clk cycles, writing 0x11 to addr 3 and then 0x22 to addr 4 -> both registers are updated.
REQ-034 SPI_READBACK_EN: write 0x5A to addr 0x02, then read addr 0x02 -> cipo bits 8..15 = 0x5A MSB first; without the macro, cipo = 0 throughout.
